// File: rtl/spi_boot_loader.sv
// spi_boot_loader: post-reset sequencer for the SPI0 flash port.
// Holds the CPU in reset, wakes the flash (0xAB), waits WAKE_CYC clocks with
// chip select high, issues a standard read (0x03 + 24-bit address), then copies
// LEN bytes into RAM through a single-cycle write strobe. It then releases
// cpu_reset and raises done in the same cycle.
//
// SPI is mode 0. SCLK idles low. MOSI changes only together with a falling
// SCLK edge, or when chip select falls. MISO is sampled on the clk edge that
// raises SCLK.
//
// Cycle count with D = CLK_DIV: number the clk rising edges after reset_n
// releases from 1. Edge 1 leaves IDLE. done/cpu_reset change on edge
//   N = 1 + 16*D + WAKE_CYC + 64*D + 16*D*LEN + D
// The fixed pipeline term is 1. The outputs are registered, so done reads 1
// starting in clk cycle N+1 after release.
module spi_boot_loader #(
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] FLASH_ADDR = 24'h040000,
  parameter logic [15:0] LEN        = 16'd8192,
  parameter logic [15:0] RAM_BASE   = 16'h0000,
  parameter logic [15:0] WAKE_CYC   = 16'd64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        cpu_reset,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, WAKE, GAP, CMD, DATA, FIN, DONE} state_t;

  // All sequential state lives in one record, so reset and update stay in one place.
  typedef struct packed {
    state_t      state;
    logic [15:0] cnt;       // SCLK half-period divider, GAP timer, FIN timer
    logic        sclk;
    logic        cs_n;
    logic [31:0] tx;        // MSB drives MOSI; zeros shift in behind the data
    logic [6:0]  rx;        // first seven bits of the byte being received
    logic [4:0]  bit_cnt;
    logic [15:0] byte_cnt;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        cpu_reset;
    logic        done;
  } regs_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = WAKE_CYC - 16'd1;

  localparam regs_t RESET_REGS = '{
    state:     IDLE,
    cnt:       16'd0,
    sclk:      1'b0,
    cs_n:      1'b1,
    tx:        32'd0,
    rx:        7'd0,
    bit_cnt:   5'd0,
    byte_cnt:  16'd0,
    ram_addr:  RAM_BASE,
    ram_wdata: 8'd0,
    ram_we:    1'b0,
    cpu_reset: 1'b1,
    done:      1'b0
  };

  regs_t r, r_d;
  logic  tick;
  logic  last_bit;

  assign tick = (r.cnt == DIV_LAST);

  // Decide whether the falling edge now due ends the current shift phase.
  always_comb begin
    last_bit = 1'b0;
    unique case (r.state)
      WAKE:    last_bit = (r.bit_cnt == 5'd7);
      CMD:     last_bit = (r.bit_cnt == 5'd31);
      DATA:    last_bit = (r.bit_cnt[2:0] == 3'd7) && (r.byte_cnt == LEN);
      default: last_bit = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    // NOTE: start from the current register value so that every field is
    // assigned on every path. This means no latch can be inferred.
    r_d        = r;
    r_d.ram_we = 1'b0;
    if (r.ram_we) r_d.ram_addr = r.ram_addr + 16'd1;

    unique case (r.state)
      IDLE: begin
        r_d.state   = WAKE;
        r_d.cs_n    = 1'b0;
        r_d.tx      = {8'hAB, 24'h000000};
        r_d.cnt     = 16'd0;
        r_d.bit_cnt = 5'd0;
      end

      WAKE, CMD, DATA: begin
        r_d.cnt = tick ? 16'd0 : r.cnt + 16'd1;
        if (tick && !r.sclk) begin
          // Rising edge: sample MISO; the 8th sample of a byte triggers the write.
          r_d.sclk = 1'b1;
          if (r.state == DATA) begin
            r_d.rx = {r.rx[5:0], spi_miso};
            if (r.bit_cnt[2:0] == 3'd7) begin
              r_d.ram_we    = 1'b1;
              r_d.ram_wdata = {r.rx, spi_miso};
              r_d.byte_cnt  = r.byte_cnt + 16'd1;
            end
          end
        end else if (tick) begin
          // Falling edge: present the next MOSI bit (zeros once tx is drained).
          r_d.sclk    = 1'b0;
          r_d.bit_cnt = r.bit_cnt + 5'd1;
          r_d.tx      = {r.tx[30:0], 1'b0};
          if (last_bit) begin
            unique case (r.state)
              WAKE: begin
                r_d.state = GAP;
                r_d.cs_n  = 1'b1;
              end
              CMD: begin
                r_d.state   = DATA;
                r_d.bit_cnt = 5'd0;
              end
              default: begin
                r_d.state = FIN;
                r_d.cs_n  = 1'b1;
              end
            endcase
          end
        end
      end

      GAP: begin
        if (r.cnt == GAP_LAST) begin
          r_d.state   = CMD;
          r_d.cs_n    = 1'b0;
          r_d.tx      = {8'h03, FLASH_ADDR};
          r_d.cnt     = 16'd0;
          r_d.bit_cnt = 5'd0;
        end else begin
          r_d.cnt = r.cnt + 16'd1;
        end
      end

      FIN: begin
        if (r.cnt == DIV_LAST) begin
          r_d.state     = DONE;
          r_d.cnt       = 16'd0;
          r_d.cpu_reset = 1'b0;
          r_d.done      = 1'b1;
        end else begin
          r_d.cnt = r.cnt + 16'd1;
        end
      end

      DONE: begin
        r_d.state = DONE;
      end

      default: begin
        r_d = RESET_REGS;
      end
    endcase
  end

  // State register; reset_n aborts any transfer immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // updates from the same pre-edge values.
    if (!reset_n) r <= RESET_REGS;
    else          r <= r_d;
  end

  assign spi_sclk  = r.sclk;
  assign spi_mosi  = r.tx[31];
  assign spi_cs_n  = r.cs_n;
  assign ram_addr  = r.ram_addr;
  assign ram_wdata = r.ram_wdata;
  assign ram_we    = r.ram_we;
  assign cpu_reset = r.cpu_reset;
  assign done      = r.done;

endmodule
